// File: rtl/traffic_light_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_light_pkg
//  Purpose  : Phase encodings, default phase lengths and the legal phase
//             successor function shared by the light controller and monitor.
//  Revision : 1.0  initial release
// ============================================================================
package traffic_light_pkg;

  typedef enum logic [1:0] {
    PH_RED    = 2'd0,
    PH_YELLOW = 2'd1,
    PH_GREEN  = 2'd2,
    PH_IDLE   = 2'd3
  } phase_e;

  localparam int RED_LEN   = 61;
  localparam int GREEN_LEN = 61;
  localparam int YEL_LEN   = 4;

  // Legal successor of a phase; IDLE has no successor and maps to itself.
  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_RED:    return PH_GREEN;
      PH_GREEN:  return PH_YELLOW;
      PH_YELLOW: return PH_RED;
      default:   return PH_IDLE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/tl_lamp_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tl_lamp_decode
//  Purpose  : Combinational decode of the three lamps into a phase. Exactly
//             one lamp lit is a valid phase; anything else is invalid.
//  Revision : 1.0  initial release
// ============================================================================
module tl_lamp_decode
  import traffic_light_pkg::*;
(
  input  logic   red_i,
  input  logic   yellow_i,
  input  logic   green_i,
  output logic   valid_o,
  output phase_e lamp_o
);

  // One-hot lamp pattern to phase; all other patterns report invalid/IDLE.
  always_comb begin
    valid_o = 1'b0;
    lamp_o  = PH_IDLE;
    case ({red_i, yellow_i, green_i})
      3'b100: begin valid_o = 1'b1; lamp_o = PH_RED;    end
      3'b010: begin valid_o = 1'b1; lamp_o = PH_YELLOW; end
      3'b001: begin valid_o = 1'b1; lamp_o = PH_GREEN;  end
      default: begin valid_o = 1'b0; lamp_o = PH_IDLE; end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_light_monitor
//  Purpose  : Receiving-end checker for red/yellow/green lamps. Tracks the
//             current phase and its duration, reports completed phase
//             lengths, flags one-hot, ordering and timing violations, and
//             counts complete correct light cycles.
//  Revision : 1.0  initial release
// ============================================================================
module traffic_light_monitor #(
  parameter int RED_LEN   = traffic_light_pkg::RED_LEN,
  parameter int GREEN_LEN = traffic_light_pkg::GREEN_LEN,
  parameter int YEL_LEN   = traffic_light_pkg::YEL_LEN,
  parameter int TOL       = 0,
  parameter int CW        = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          red_i,
  input  logic          yellow_i,
  input  logic          green_i,
  input  logic          clr_i,
  output logic [1:0]    phase_o,
  output logic          len_valid_o,
  output logic [CW-1:0] phase_len_o,
  output logic [1:0]    last_phase_o,
  output logic          err_onehot_o,
  output logic          err_seq_o,
  output logic          err_timing_o,
  output logic [15:0]   cycle_cnt_o
);
  import traffic_light_pkg::*;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Nominal length of a phase; IDLE never gets timed.
  function automatic int exp_len(input phase_e p);
    case (p)
      PH_RED:    return RED_LEN;
      PH_YELLOW: return YEL_LEN;
      PH_GREEN:  return GREEN_LEN;
      default:   return 0;
    endcase
  endfunction

  logic   w_valid;
  phase_e w_lamp;

  tl_lamp_decode u_decode (
    .red_i    (red_i),
    .yellow_i (yellow_i),
    .green_i  (green_i),
    .valid_o  (w_valid),
    .lamp_o   (w_lamp)
  );

  phase_e        phase_q,      phase_d;
  logic [CW-1:0] cnt_q,        cnt_d;
  logic          first_q,      first_d;
  logic          cycle_ok_q,   cycle_ok_d;
  logic          len_valid_q,  len_valid_d;
  logic [CW-1:0] phase_len_q,  phase_len_d;
  logic [1:0]    last_phase_q, last_phase_d;
  logic          err_onehot_q, err_onehot_d;
  logic          err_seq_q,    err_seq_d;
  logic          err_timing_q, err_timing_d;
  logic [15:0]   cycle_cnt_q,  cycle_cnt_d;

  logic w_err_onehot;
  logic w_err_seq;
  logic w_err_timing;
  logic w_cycle_inc;
  int   w_cnt;
  int   w_exp;

  // Next-state: phase tracking, duration counting, reporting and checks.
  always_comb begin
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    first_d      = first_q;
    cycle_ok_d   = cycle_ok_q;
    len_valid_d  = 1'b0;
    phase_len_d  = phase_len_q;
    last_phase_d = last_phase_q;
    w_err_onehot = 1'b0;
    w_err_seq    = 1'b0;
    w_err_timing = 1'b0;
    w_cycle_inc  = 1'b0;
    w_cnt        = int'(cnt_q);
    w_exp        = exp_len(phase_q);

    if (!w_valid) begin
      w_err_onehot = 1'b1;
      phase_d      = PH_IDLE;
      cnt_d        = '0;
      first_d      = 1'b1;
    end else if (phase_q == PH_IDLE) begin
      // A phase entered from IDLE started before we saw it: never timed.
      phase_d    = w_lamp;
      cnt_d      = CNT_ONE;
      first_d    = 1'b1;
      cycle_ok_d = 1'b0;
    end else if (w_lamp == phase_q) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
      // Overstay watchdog fires as soon as the count passes the window.
      if (w_cnt + 1 > w_exp + TOL) begin
        w_err_timing = 1'b1;
      end
    end else begin
      phase_d = w_lamp;
      cnt_d   = CNT_ONE;
      first_d = 1'b0;
      if (w_lamp != next_phase(phase_q)) begin
        w_err_seq = 1'b1;
      end
      if (!first_q) begin
        len_valid_d  = 1'b1;
        phase_len_d  = cnt_q;
        last_phase_d = phase_q;
        if ((w_cnt < w_exp - TOL) || (w_cnt > w_exp + TOL)) begin
          w_err_timing = 1'b1;
        end
      end
      if ((phase_q == PH_YELLOW) && (w_lamp == PH_RED) && cycle_ok_q &&
          !first_q && !w_err_timing && !w_err_seq) begin
        w_cycle_inc = 1'b1;
      end
      if (w_lamp == PH_RED) begin
        cycle_ok_d = 1'b1;
      end
    end

    if (w_err_onehot || w_err_seq || w_err_timing) begin
      cycle_ok_d = 1'b0;
    end

    // Sticky flags: a new error in the clear cycle still sets the flag.
    err_onehot_d = (err_onehot_q & ~clr_i) | w_err_onehot;
    err_seq_d    = (err_seq_q    & ~clr_i) | w_err_seq;
    err_timing_d = (err_timing_q & ~clr_i) | w_err_timing;

    cycle_cnt_d = clr_i ? 16'd0 : cycle_cnt_q;
    if (w_cycle_inc) begin
      cycle_cnt_d = cycle_cnt_d + 16'd1;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q      <= PH_IDLE;
      cnt_q        <= '0;
      first_q      <= 1'b1;
      cycle_ok_q   <= 1'b0;
      len_valid_q  <= 1'b0;
      phase_len_q  <= '0;
      last_phase_q <= 2'd0;
      err_onehot_q <= 1'b0;
      err_seq_q    <= 1'b0;
      err_timing_q <= 1'b0;
      cycle_cnt_q  <= 16'd0;
    end else begin
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
      cycle_ok_q   <= cycle_ok_d;
      len_valid_q  <= len_valid_d;
      phase_len_q  <= phase_len_d;
      last_phase_q <= last_phase_d;
      err_onehot_q <= err_onehot_d;
      err_seq_q    <= err_seq_d;
      err_timing_q <= err_timing_d;
      cycle_cnt_q  <= cycle_cnt_d;
    end
  end

  assign phase_o      = phase_q;
  assign len_valid_o  = len_valid_q;
  assign phase_len_o  = phase_len_q;
  assign last_phase_o = last_phase_q;
  assign err_onehot_o = err_onehot_q;
  assign err_seq_o    = err_seq_q;
  assign err_timing_o = err_timing_q;
  assign cycle_cnt_o  = cycle_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_light_monitor
//  Purpose  : Directed-vector bench with a phase-report scoreboard for
//             traffic_light_monitor (default parameters).
//  Revision : 1.0  initial release
// ============================================================================
module tb_traffic_light_monitor;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        red_i, yellow_i, green_i, clr_i;
  logic [1:0]  phase_o;
  logic        len_valid_o;
  logic [7:0]  phase_len_o;
  logic [1:0]  last_phase_o;
  logic        err_onehot_o, err_seq_o, err_timing_o;
  logic [15:0] cycle_cnt_o;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  typedef struct packed {
    logic [1:0] ph;
    logic [7:0] len;
  } rpt_t;

  rpt_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  traffic_light_monitor u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .red_i        (red_i),
    .yellow_i     (yellow_i),
    .green_i      (green_i),
    .clr_i        (clr_i),
    .phase_o      (phase_o),
    .len_valid_o  (len_valid_o),
    .phase_len_o  (phase_len_o),
    .last_phase_o (last_phase_o),
    .err_onehot_o (err_onehot_o),
    .err_seq_o    (err_seq_o),
    .err_timing_o (err_timing_o),
    .cycle_cnt_o  (cycle_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Hold a lamp pattern for n sampling edges; returns 1 time unit after the last edge.
  task automatic drive(input logic [2:0] lamps, input int n);
    for (int i = 0; i < n; i++) begin
      {red_i, yellow_i, green_i} = lamps;
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic push(input logic [1:0] ph, input logic [7:0] len);
    rpt_t e;
    e.ph  = ph;
    e.len = len;
    exp_q.push_back(e);
  endtask

  // Monitor: every length report must match the oldest expected report.
  always @(negedge clk_i) begin
    rpt_t e;
    if (rst_ni && len_valid_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_len_valid: got last_phase=%0d phase_len=%0d, expected no pulse",
                 last_phase_o, phase_len_o);
      end else begin
        e = exp_q.pop_front();
        check("last_phase", 32'(last_phase_o), 32'(e.ph));
        check("phase_len",  32'(phase_len_o),  32'(e.len));
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    clr_i  = 1'b0;
    {red_i, yellow_i, green_i} = R;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_phase",      32'(phase_o), 32'd3);
    check("rst_len_valid",  32'(len_valid_o), 32'd0);
    check("rst_phase_len",  32'(phase_len_o), 32'd0);
    check("rst_last_phase", 32'(last_phase_o), 32'd0);
    check("rst_errs",       32'({err_onehot_o, err_seq_o, err_timing_o}), 32'd0);
    check("rst_cycle_cnt",  32'(cycle_cnt_o), 32'd0);
    rst_ni = 1'b1;

    // Legal sequence starting with a partial red.
    drive(R, 30);
    check("partial_red_phase", 32'(phase_o), 32'd0);
    drive(G, 61);
    push(2'd2, 8'd61);
    drive(Y, 4);
    push(2'd1, 8'd4);
    drive(R, 1);
    check("cycle_cnt_after_partial", 32'(cycle_cnt_o), 32'd0);
    drive(R, 60);
    push(2'd0, 8'd61);
    drive(G, 61);
    push(2'd2, 8'd61);
    drive(Y, 4);
    push(2'd1, 8'd4);
    drive(R, 1);
    check("cycle_cnt_full_cycle", 32'(cycle_cnt_o), 32'd1);
    check("legal_no_errs", 32'({err_onehot_o, err_seq_o, err_timing_o}), 32'd0);
    drive(R, 60);
    push(2'd0, 8'd61);

    // Green overstay.
    drive(G, 61);
    check("green61_no_timing_err", 32'(err_timing_o), 32'd0);
    drive(G, 1);
    check("green62_timing_err", 32'(err_timing_o), 32'd1);
    check("green62_phase", 32'(phase_o), 32'd2);

    // Short yellow, then red.
    push(2'd2, 8'd62);
    drive(Y, 3);
    push(2'd1, 8'd3);
    drive(R, 1);
    check("short_yel_timing_err", 32'(err_timing_o), 32'd1);
    check("short_yel_cycle_cnt", 32'(cycle_cnt_o), 32'd1);
    check("short_yel_phase", 32'(phase_o), 32'd0);

    // Illegal red->yellow, clear, then clear with a new illegal transition.
    drive(R, 4);
    push(2'd0, 8'd5);
    drive(Y, 1);
    check("red_to_yel_err_seq", 32'(err_seq_o), 32'd1);
    clr_i = 1'b1;
    drive(Y, 1);
    clr_i = 1'b0;
    check("clr_errs", 32'({err_onehot_o, err_seq_o, err_timing_o}), 32'd0);
    check("clr_cycle_cnt", 32'(cycle_cnt_o), 32'd0);
    push(2'd1, 8'd2);
    clr_i = 1'b1;
    drive(G, 1);
    clr_i = 1'b0;
    check("clr_and_err_seq", 32'(err_seq_o), 32'd1);

    // Two lamps lit: one-hot violation, back to IDLE, next red is partial.
    drive(R | G, 1);
    check("onehot_err", 32'(err_onehot_o), 32'd1);
    check("onehot_phase", 32'(phase_o), 32'd3);
    check("onehot_no_len_valid", 32'(len_valid_o), 32'd0);
    drive(R, 10);
    check("post_onehot_red", 32'(phase_o), 32'd0);
    drive(G, 5);

    // Asynchronous reset mid-green.
    rst_ni = 1'b0;
    #1;
    check("async_rst_phase", 32'(phase_o), 32'd3);
    check("async_rst_outs",
          32'({len_valid_o, phase_len_o, last_phase_o, err_onehot_o, err_seq_o, err_timing_o}),
          32'd0);
    check("async_rst_cycle_cnt", 32'(cycle_cnt_o), 32'd0);
    #1;
    rst_ni = 1'b1;
    drive(G, 3);
    drive(Y, 4);
    push(2'd1, 8'd4);
    drive(R, 2);
    check("post_rst_phase", 32'(phase_o), 32'd0);

    repeat (3) @(posedge clk_i);
    #1;
    check("reports_outstanding", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
